// File: rtl/ctrl_mem_sequencer.sv
// Purpose : config memory + replay sequencer feeding the tile crossbar's recv_opt port.
// Latency : start accepted at edge N -> mem[0] presented in cycle N+1; one config per handshake.
// Backpressure: send_ctrl__rdy low holds pc and message; all receive ports stall (rdy=0) while running.
//
// Ports:
//   clk, reset          - single clock, asynchronous active-high reset of control state
//   recv_waddr__*       - write address (AW bits), ready in IDLE only
//   recv_ctrl__*        - 49-bit config word written together with recv_waddr
//   recv_start__*       - {num_ctrl[AW:0], iterations[7:0]}; iterations 0 = run forever
//   send_ctrl__*        - config stream toward the crossbar, all-zero (OPT_START) when idle
//   done                - one-cycle pulse after the final handshake of a finite run
//
// Config word layout assumed by users of this block: ctrl opcode in [48:43], rest below.
module ctrl_mem_sequencer #(
    parameter  int CTRL_MEM_SIZE = 8,
    localparam int AW            = $clog2(CTRL_MEM_SIZE)
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              recv_waddr__en,
    input  logic [AW-1:0]     recv_waddr__msg,
    output logic              recv_waddr__rdy,

    input  logic              recv_ctrl__en,
    input  logic [48:0]       recv_ctrl__msg,
    output logic              recv_ctrl__rdy,

    input  logic              recv_start__en,
    input  logic [AW+8:0]     recv_start__msg,
    output logic              recv_start__rdy,

    output logic              send_ctrl__en,
    output logic [48:0]       send_ctrl__msg,
    input  logic              send_ctrl__rdy,

    output logic              done
);

    localparam int         CW         = 49;
    localparam logic [AW:0] MEM_SIZE_W = (AW+1)'(CTRL_MEM_SIZE);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_pc;
    logic [AW-1:0]   w_pc_nxt;
    logic [AW-1:0]   r_last_pc;       // num_ctrl-1, stored pre-decremented
    logic [AW-1:0]   w_last_pc_nxt;
    logic [7:0]      r_iter_cnt;
    logic [7:0]      w_iter_cnt_nxt;
    logic [7:0]      r_iterations;
    logic [7:0]      w_iterations_nxt;
    logic            r_done;
    logic            w_done_nxt;

    // Config storage: deliberately not reset so a program survives reset.
    logic [CW-1:0]   r_mem [CTRL_MEM_SIZE];

    // ------------------------------------------------------------------
    // Start command decode
    // ------------------------------------------------------------------
    logic [AW:0]     w_start_num;
    logic [AW:0]     w_num_eff;
    logic [AW-1:0]   w_start_last_pc;
    logic [7:0]      w_start_iters;

    assign w_start_num   = recv_start__msg[AW+8:8];
    assign w_start_iters = recv_start__msg[7:0];

    // num_ctrl of 0 or beyond the memory replays the whole memory.
    assign w_num_eff = ((w_start_num == '0) || (w_start_num > MEM_SIZE_W)) ? MEM_SIZE_W
                                                                           : w_start_num;
    // For a full-memory run the low AW bits are 0, so the decrement wraps to SIZE-1.
    assign w_start_last_pc = w_num_eff[AW-1:0] - AW'(1);

    // ------------------------------------------------------------------
    // Handshake / end-of-run detection
    // ------------------------------------------------------------------
    logic w_running;
    logic w_hs;
    logic w_at_last;
    logic w_last_iter;
    logic w_write;

    assign w_running   = (r_state == RUN);
    assign w_hs        = w_running & send_ctrl__rdy;
    assign w_at_last   = (r_pc == r_last_pc);
    // iterations==0 never terminates; iter_cnt just wraps.
    assign w_last_iter = (r_iterations != 8'd0) && (r_iter_cnt == (r_iterations - 8'd1));
    assign w_write     = ~w_running & recv_waddr__en & recv_ctrl__en;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_last_pc_nxt    = r_last_pc;
        w_iter_cnt_nxt   = r_iter_cnt;
        w_iterations_nxt = r_iterations;
        w_done_nxt       = 1'b0;

        case (r_state)
            IDLE: begin
                if (recv_start__en) begin
                    w_state_nxt      = RUN;
                    w_pc_nxt         = '0;
                    w_iter_cnt_nxt   = 8'd0;
                    w_last_pc_nxt    = w_start_last_pc;
                    w_iterations_nxt = w_start_iters;
                end
            end
            RUN: begin
                if (w_hs) begin
                    if (w_at_last) begin
                        w_pc_nxt       = '0;
                        w_iter_cnt_nxt = r_iter_cnt + 8'd1;
                        if (w_last_iter) begin
                            w_state_nxt = IDLE;
                            w_done_nxt  = 1'b1;
                        end
                    end else begin
                        w_pc_nxt = r_pc + AW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_pc         <= '0;
            r_last_pc    <= '0;
            r_iter_cnt   <= 8'd0;
            r_iterations <= 8'd0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_last_pc    <= w_last_pc_nxt;
            r_iter_cnt   <= w_iter_cnt_nxt;
            r_iterations <= w_iterations_nxt;
            r_done       <= w_done_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Memory write port (idle only; a lone address or data beat is dropped)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[recv_waddr__msg] <= recv_ctrl__msg;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign recv_waddr__rdy = ~w_running;
    assign recv_ctrl__rdy  = ~w_running;
    assign recv_start__rdy = ~w_running;

    assign send_ctrl__en   = w_running;
    // Idle forces OPT_START (all zero) so the crossbar stays inert.
    assign send_ctrl__msg  = w_running ? r_mem[r_pc] : '0;

    assign done            = r_done;

endmodule

// File: doc/ctrl_mem_sequencer.md
# ctrl_mem_sequencer

Configuration memory and sequencer that sits directly upstream of the tile crossbar and drives its `recv_opt` port. It is loaded with up to `CTRL_MEM_SIZE` words of `CGRAConfig_6_4_6_8` while idle. On a start command it replays entries `0..num_ctrl-1` cyclically for a programmed number of iterations, presenting one config per accepted handshake. When idle it presents an all-zero config (`ctrl == OPT_START`), which keeps the crossbar inert.

## Interface
- `CTRL_MEM_SIZE`, default 8: number of config entries; must be a power of two, minimum 2.
- `AW`, default `$clog2(CTRL_MEM_SIZE)`: address width. Derived; not overridden.
- `clk` input, 1 bit: single clock. All state changes on the rising edge.
- `reset` input, 1 bit: asynchronous, active-high. Clears all control state immediately.
- `recv_waddr__en` input, 1: write-address valid.
- `recv_waddr__msg` input, `AW`: entry to write.
- `recv_waddr__rdy` output, 1: write port ready.
- `recv_ctrl__en` input, 1: config write valid.
- `recv_ctrl__msg` input, `CGRAConfig_6_4_6_8` (49 bits): config word.
- `recv_ctrl__rdy` output, 1: config port ready.
- `recv_start__en` input, 1: start command.
- `recv_start__msg` input, `AW+1+8`:
  - `[AW+8:8]` = `num_ctrl`
  - `[7:0]` = `iterations`; 0 means run forever.
- `recv_start__rdy` output, 1: start accepted when high.
- `send_ctrl__en` output, 1: config valid toward the crossbar.
- `send_ctrl__msg` output, `CGRAConfig_6_4_6_8`: current config.
- `send_ctrl__rdy` input, 1: crossbar `recv_opt__rdy`.
- `done` output, 1: one-cycle pulse when a finite run completes.

## Operation
- States: `IDLE` and `RUN`. Reset state is `IDLE`.
- **IDLE**
  - `recv_waddr__rdy`, `recv_ctrl__rdy` and `recv_start__rdy` are all 1.
  - A write occurs only when `recv_waddr__en` and `recv_ctrl__en` are both 1 in the same cycle. Then `mem[waddr] <= ctrl` at the clock edge.
  - If only one of the two enables is 1, nothing is written and that beat is dropped.
  - `send_ctrl__en` = 0 and `send_ctrl__msg` = 0.
- **IDLE → RUN**, on `recv_start__en`:
  - `pc <= 0`, `iter_cnt <= 0`.
  - Latch `num_ctrl` and `iterations`.
  - `num_ctrl` of 0 or greater than `CTRL_MEM_SIZE` is clamped to `CTRL_MEM_SIZE`.
- **Start and write in the same cycle:** the write completes. It is visible at `pc` 0 if `waddr` is 0.
- **RUN**
  - All three receive rdys are 0. Writes and starts are ignored.
  - `send_ctrl__en` = 1.
  - `send_ctrl__msg` = `mem[pc]`, a combinational read of the registered `pc`.
- **Handshake** is `send_ctrl__en & send_ctrl__rdy`. On a handshake:
  - If `pc == num_ctrl-1`: `pc <= 0` and `iter_cnt <= iter_cnt+1` (8-bit).
  - Otherwise `pc <= pc+1`.
  - With `send_ctrl__rdy` = 0, `pc` holds and the msg is stable.
- **RUN → IDLE**
  - Occurs on a handshake at `pc == num_ctrl-1` when `iterations != 0` and `iter_cnt == iterations-1`.
  - `done` is registered 1 for the following cycle only.
- **Infinite run** (`iterations == 0`): `iter_cnt` wraps at 255 → 0 and the run never terminates. Only `reset` exits.
- **Memory**: not affected by `reset`. Contents survive a reset. Contents after power-up are undefined.
- **Reset mid-run**: `state`, `pc`, `iter_cnt` and `done` are asynchronously set to `IDLE`/0/0/0. Outputs take their IDLE values with no clock needed.

## Timing
- Output values while `reset` is asserted:
  - `send_ctrl__en` = 0, `send_ctrl__msg` = 0, `done` = 0.
  - The three receive rdys = 1 (IDLE values).
- Start latency: start accepted at edge N; `send_ctrl__en` = 1 with `mem[0]` from edge N, i.e. in the cycle after the start beat.
- Throughput: one config per cycle while `send_ctrl__rdy` = 1.
- Last handshake at edge M:
  - `send_ctrl__en` = 0 from edge M.
  - `done` = 1 in cycle M..M+1.
  - rdys return to 1 from edge M.
  - A new start is accepted at edge M+1 at the earliest.
- Write-to-read: a word written at edge N is readable from cycle N+1.

## Test plan
- **Load and run:** write entries 0..3 with `ctrl` = 1..4, start with `num_ctrl`=4, `iterations`=2, `send_ctrl__rdy`=1.
  - `send_ctrl__msg.ctrl` sequence is 1,2,3,4,1,2,3,4 on 8 consecutive cycles.
  - `done` pulses once, one cycle after the last beat.
  - `msg` = 0 afterwards.
- **Backpressure:** same program as above, with `send_ctrl__rdy` dropped for 3 cycles while `pc`=2.
  - `msg.ctrl` holds 3 for those cycles.
  - The sequence resumes with no skipped or duplicated entry.
  - Total handshakes = 8.
- **Clamp and wrap:** start with `num_ctrl`=0 and `iterations`=1 (`CTRL_MEM_SIZE`=8).
  - Exactly 8 entries are emitted, `pc` 0..7.
  - Then `IDLE` and `done`.
- **Writes blocked in RUN:** attempt a write to entry 1 (`ctrl`=9) during a run.
  - `recv_ctrl__rdy` = 0 and the entry is unchanged.
  - A start attempted during the run is ignored.
- **Async reset mid-run:** with `iterations`=0 and the run at `pc`=2, assert `reset` between clock edges.
  - `send_ctrl__en` falls before the next edge.
  - After release, a new start replays entry 0 with its original contents (memory retained).
- **Half write:** drive `recv_waddr__en` without `recv_ctrl__en`. No entry changes.
